// File: rtl/fpu_req_scheduler_if.sv
// Requester-side bus of the FPU scheduler.
//   master: client side (drives requests, receives acceptance and response)
//   slave : scheduler side
`timescale 1ns/1ps
interface fpu_req_scheduler_if #(
   parameter int unsigned N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ*32-1:0] req_op_a;
   logic [N_REQ*32-1:0] req_op_b;
   logic [N_REQ-1:0]    req_ready;
   logic [N_REQ-1:0]    rsp_valid;
   logic [31:0]         rsp_data;
   logic [3:0]          rsp_status;

   modport master (
      output req_valid, req_op_a, req_op_b,
      input  req_ready, rsp_valid, rsp_data, rsp_status
   );

   modport slave (
      input  req_valid, req_op_a, req_op_b,
      output req_ready, rsp_valid, rsp_data, rsp_status
   );
endinterface

// File: rtl/fpu_req_scheduler.sv
// Round-robin scheduler sharing one FPU adder among N_REQ requesters.
// Ports:
//   clock_100Khz, reset (async, active-low)
//   bus           : requester handshake (valid/operands in, ready/response out)
//   busy          : high whenever not IDLE
//   fpu_op_a/b    : operands frozen for the whole FPU pass
//   fpu_clear_n   : FPU reset, low for one cycle at each grant and during reset
//   fpu_data_in, fpu_status_in : FPU result, captured at the end of RUN
`timescale 1ns/1ps
module fpu_req_scheduler #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned LATENCY = 32,
   parameter int unsigned CNT_W   = 6
) (
   input  logic                 clock_100Khz,
   input  logic                 reset,
   fpu_req_scheduler_if.slave   bus,
   output logic                 busy,
   output logic [31:0]          fpu_op_a,
   output logic [31:0]          fpu_op_b,
   output logic                 fpu_clear_n,
   input  logic [31:0]          fpu_data_in,
   input  logic [3:0]           fpu_status_in
);

   localparam int unsigned IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0]  ST_EXACT = 4'd2;

   typedef enum logic [1:0] {IDLE, GRANT, RUN, RESPOND} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   last_q, last_d;
   logic [N_REQ-1:0]   ready_q, ready_d;
   logic [N_REQ-1:0]   rspv_q, rspv_d;
   logic [31:0]        rsp_data_q, rsp_data_d;
   logic [3:0]         rsp_st_q, rsp_st_d;
   logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
   logic               clear_q, clear_d;
   logic               busy_q, busy_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [31:0]        sel_a, sel_b;

   // Round-robin search starting one past the last grant, wrapping at N_REQ.
   always_comb begin : arbiter
      int unsigned idx;
      idx       = 0;
      win_found = 1'b0;
      win_idx   = last_q;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         idx = (32'(last_q) + k) % N_REQ;
         if (!win_found && bus.req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(idx);
         end
      end
   end

   // Operand mux for the winner.
   always_comb begin : op_select
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == win_idx) begin
            sel_a = bus.req_op_a[32*i +: 32];
            sel_b = bus.req_op_b[32*i +: 32];
         end
      end
   end

   // Next state and next values of all registered outputs.
   always_comb begin : fsm_next
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      ready_d    = '0;
      rspv_d     = '0;
      clear_d    = 1'b0;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      rsp_data_d = rsp_data_q;
      rsp_st_d   = rsp_st_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               last_d  = win_idx;
               ready_d = N_REQ'(1) << win_idx;
               clear_d = 1'b1;
               op_a_d  = sel_a;
               op_b_d  = sel_b;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(LATENCY - 1)) begin
               state_d    = RESPOND;
               // last_q holds the current grant from GRANT onward
               rspv_d     = N_REQ'(1) << last_q;
               rsp_data_d = fpu_data_in;
               rsp_st_d   = fpu_status_in;
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         ready_q    <= '0;
         rspv_q     <= '0;
         rsp_data_q <= '0;
         rsp_st_q   <= ST_EXACT;
         op_a_q     <= '0;
         op_b_q     <= '0;
         clear_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         ready_q    <= ready_d;
         rspv_q     <= rspv_d;
         rsp_data_q <= rsp_data_d;
         rsp_st_q   <= rsp_st_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         clear_q    <= clear_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.rsp_valid  = rspv_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_status = rsp_st_q;
   assign busy           = busy_q;
   assign fpu_op_a       = op_a_q;
   assign fpu_op_b       = op_b_q;
   // clear_q is a flop, so this stays glitch-free
   assign fpu_clear_n    = reset & ~clear_q;

endmodule

// File: doc/fpu_req_scheduler.md
# fpu_req_scheduler

Round-robin scheduler that shares one FPU adder instance among `N_REQ` requesters. It arbitrates pending requests and presents the winner's operands to the FPU. Before each operation it pulses the FPU's active-low clear so the FPU state machine starts from DECODE. It then holds the operands stable for a fixed `LATENCY` window and returns the captured result and status to the granted requester. It sits between the client blocks and the FPU datapath; the FPU is connected only through this block.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LATENCY`, 32: cycles operands are held after clear before result capture. Must cover a worst-case FPU pass: 5 states + 21 normalize steps + margin. Minimum 2.
- `CNT_W`, 6: width of the latency counter. Must satisfy 2^CNT_W > LATENCY.
- `clock_100Khz` in 1: system clock.
- `reset` in 1: asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request pending.
- `req_op_a` in N_REQ*32: operand A; requester i uses bits [32i+31:32i].
- `req_op_b` in N_REQ*32: operand B, packed the same way.
- `req_ready` out N_REQ: one-hot, one-cycle acceptance pulse.
- `rsp_valid` out N_REQ: one-hot, one-cycle response pulse.
- `rsp_data` out 32: result {sign, exp[9:0], mant[20:0]}, valid with `rsp_valid`.
- `rsp_status` out 4: FPU status code (OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3), valid with `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `fpu_op_a` out 32: operand A driven to the FPU.
- `fpu_op_b` out 32: operand B driven to the FPU.
- `fpu_clear_n` out 1: FPU reset. Equals `reset` AND NOT `clear_pulse`.
- `fpu_data_in` in 32: FPU data output.
- `fpu_status_in` in 4: FPU status output.

## Operation
- States:
  - IDLE → GRANT when any `req_valid` is high.
  - GRANT → RUN unconditionally.
  - RUN → RESPOND when `cnt == LATENCY-1`.
  - RESPOND → IDLE unconditionally.
- Arbitration (IDLE only): round-robin.
  - Search starts at `(last_grant+1) mod N_REQ`; the first set `req_valid` wins.
  - `last_grant` updates on entering GRANT. It resets to N_REQ-1, so requester 0 has priority first.
  - Wrap-around: the search continues past index N_REQ-1 back to 0.
- GRANT:
  - `req_ready[g]`=1.
  - The winner's operands are latched into `fpu_op_a`/`fpu_op_b`.
  - `clear_pulse`=1, so `fpu_clear_n`=0 for this cycle.
  - `cnt` is cleared.
- RUN:
  - `cnt` increments each cycle.
  - Operands stay frozen; `req_*` changes are ignored.
- RESPOND:
  - `rsp_data` ← `fpu_data_in` and `rsp_status` ← `fpu_status_in`, registered on the RUN→RESPOND edge.
  - `rsp_valid[g]`=1 for exactly one cycle.
- `rsp_data` and `rsp_status` hold their last values until the next capture.
- Requesters must hold `req_valid` and operands until they see `req_ready`.
  - A request withdrawn before GRANT is simply not served.
  - No request is lost or duplicated.
- Simultaneous requests: exactly one grant per transaction. The others wait, with starvation bounded to N_REQ-1 transactions.
- Reset mid-operation aborts the transaction:
  - No `rsp_valid` is issued.
  - The state machine, `cnt` and `last_grant` return to reset values.
  - The FPU is cleared through `fpu_clear_n`.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=2 (EXACT).
  - `busy`=0, `fpu_op_a`=0, `fpu_op_b`=0, `fpu_clear_n`=0 (follows `reset`).
  - State IDLE, `cnt`=0, `last_grant`=N_REQ-1.
- Cycle 0: IDLE samples `req_valid`.
- Cycle 1: GRANT, with `req_ready` and clear pulse.
- Cycles 2..LATENCY+1: RUN.
- Cycle LATENCY+2: RESPOND with `rsp_valid`.
- Latency from acceptance (`req_ready`) to `rsp_valid` is LATENCY+1 cycles.
- Throughput: one operation per LATENCY+3 cycles. Back-to-back requests re-enter GRANT the cycle after IDLE.
- `fpu_clear_n` low lasts exactly one cycle per operation. It is glitch-free because `clear_pulse` is a register output.

## Test plan
- Reset check:
  - Stimulus: assert `reset`=0 for 3 cycles, all `req_valid`=0.
  - Required response: all outputs at their reset values; `busy`=0; `fpu_clear_n`=0 while in reset and 1 afterwards.
- Single request, routing and timing:
  - Stimulus: FPU stub returns `fpu_data_in`=op_a^op_b and `fpu_status_in`=3. Requester 2 sends op_a=0x3FE00000, op_b=0x00000001.
  - Required response: `req_ready[2]` at cycle 1; `fpu_clear_n`=0 only at cycle 1; `rsp_valid[2]` at cycle LATENCY+2 with `rsp_data`=0x3FE00001 and `rsp_status`=3.
- Contention and fairness:
  - Stimulus: all 4 `req_valid` held high, each requester with distinct operands.
  - Required response: grants in order 0,1,2,3,0; each `rsp_data` matches its own operands; no cycle with two `rsp_valid` bits set.
- Wrap-around:
  - Stimulus: after a grant to requester 3, requesters 1 and 3 are valid.
  - Required response: requester 1 is granted next.
- Operand stability:
  - Stimulus: during RUN, change `req_op_a` and drop `req_valid` for the active requester.
  - Required response: `fpu_op_a` and `fpu_op_b` are unchanged; the response is still issued.
- Reset mid-RUN:
  - Stimulus: assert `reset` at `cnt`=10.
  - Required response: no `rsp_valid`; state returns to IDLE; the next request is granted to requester 0 first.
